// File: rtl/serial_deserializer_if.sv
// ----------------------------------------------------------------------------
// serial_deserializer_if
// Bundles the serial input side and the parallel output side of the
// serial-to-parallel converter.
//   data_i           : serial data bit, meaningful only when data_val_i = 1
//   data_val_i       : qualifies data_i on the current clock edge
//   deser_data_o     : assembled word, bit DATA_W-1 is the first bit received
//   deser_data_val_o : one-cycle strobe marking a new word on deser_data_o
// Modports:
//   master : the bit-serial source / word consumer (testbench or upstream)
//   slave  : the deserializer itself
// ----------------------------------------------------------------------------
interface serial_deserializer_if #(
  parameter int DATA_W = 16
);
  logic              data_i;
  logic              data_val_i;
  logic [DATA_W-1:0] deser_data_o;
  logic              deser_data_val_o;

  modport master (
    output data_i,
    output data_val_i,
    input  deser_data_o,
    input  deser_data_val_o
  );

  modport slave (
    input  data_i,
    input  data_val_i,
    output deser_data_o,
    output deser_data_val_o
  );
endinterface

// File: rtl/serial_deserializer.sv
// ----------------------------------------------------------------------------
// serial_deserializer
// Collects DATA_W qualified serial bits, MSB first, into one parallel word and
// presents it with a single-cycle valid strobe. No back-pressure: every
// strobed word must be taken by the downstream logic.
// Ports:
//   clk_i  : clock, all state changes on the rising edge
//   rst_ni : asynchronous active-low reset
//   bus    : serial_deserializer_if.slave
//            (data_i, data_val_i in; deser_data_o, deser_data_val_o out)
// Parameters:
//   DATA_W : word width, must be >= 2
// ----------------------------------------------------------------------------
module serial_deserializer #(
  parameter int DATA_W = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  serial_deserializer_if.slave   bus
);

  localparam int CNT_W = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

  logic [DATA_W-1:0] r_shift;
  logic [CNT_W-1:0]  r_cnt;
  logic [DATA_W-1:0] r_data;
  logic              r_data_val;

  // Shift register contents including the bit sampled on this edge; this is
  // also the completed word when the counter is at its last position.
  logic [DATA_W-1:0] w_shift_next;

  assign w_shift_next = {r_shift[DATA_W-2:0], bus.data_i};

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_shift    <= '0;
      r_cnt      <= '0;
      r_data     <= '0;
      r_data_val <= 1'b0;
    end else begin
      // Strobe defaults low so it can only ever last a single cycle.
      r_data_val <= 1'b0;
      if (bus.data_val_i) begin
        r_shift <= w_shift_next;
        if (r_cnt == CNT_LAST) begin
          // Word complete: the output word only changes here, never mid-word.
          r_data     <= w_shift_next;
          r_data_val <= 1'b1;
          r_cnt      <= '0;
        end else begin
          r_cnt <= r_cnt + CNT_W'(1);
        end
      end
    end
  end

  assign bus.deser_data_o     = r_data;
  assign bus.deser_data_val_o = r_data_val;

endmodule

// File: tb/tb_serial_deserializer.sv
module tb_serial_deserializer;

  logic clk;
  logic rst_n;
  int   n_vec;
  int   n_err;
  int   cyc;

  serial_deserializer_if #(.DATA_W(16)) bus16 ();
  serial_deserializer_if #(.DATA_W(4))  bus4  ();

  serial_deserializer #(.DATA_W(16)) dut16 (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus16)
  );

  serial_deserializer #(.DATA_W(4)) dut4 (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [15:0] word;
    int          max_gap;
    int          idle_after;
    logic [15:0] exp_word;
  } vec_t;

  vec_t tbl [6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Called at a negedge: drive inputs, let one rising edge pass, return at
  // the following negedge so outputs of that edge can be sampled.
  task automatic step16(input logic v, input logic b);
    bus16.data_val_i = v;
    bus16.data_i     = v ? b : 1'($urandom);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic step4(input logic v, input logic b);
    bus4.data_val_i = v;
    bus4.data_i     = v ? b : 1'($urandom);
    @(posedge clk);
    @(negedge clk);
  endtask

  // Sends one 16-bit word with random gaps, checks there is no strobe while
  // bits arrive, the strobe right after the last bit, and hold afterwards.
  task automatic send_word(input logic [15:0] w, input int max_gap,
                           input int idle_after, input logic [15:0] exp,
                           output int strobe_cyc);
    int g;
    strobe_cyc = -1;
    for (int i = 15; i >= 0; i--) begin
      g = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
      for (int k = 0; k < g; k++) begin
        step16(1'b0, 1'b0);
        chk("gap_no_strobe", 32'(bus16.deser_data_val_o), 32'd0);
      end
      step16(1'b1, w[i]);
      if (i > 0) begin
        chk("bit_no_strobe", 32'(bus16.deser_data_val_o), 32'd0);
      end else begin
        strobe_cyc = cyc;
        chk("strobe", 32'(bus16.deser_data_val_o), 32'd1);
        chk("word", 32'(bus16.deser_data_o), 32'(exp));
      end
    end
    for (int k = 0; k < idle_after; k++) begin
      step16(1'b0, 1'b0);
      chk("strobe_drop", 32'(bus16.deser_data_val_o), 32'd0);
      chk("word_hold", 32'(bus16.deser_data_o), 32'(exp));
    end
    $display("word 0x%04h sent (max_gap %0d) -> out 0x%04h", w, max_gap, bus16.deser_data_o);
  endtask

  initial begin
    int sc_a;
    int sc_b;
    logic [15:0] rw;
    logic [3:0]  w4;

    n_vec = 0;
    n_err = 0;
    cyc   = 0;

    tbl[0] = '{word: 16'hA5C3, max_gap: 0, idle_after: 1, exp_word: 16'hA5C3};
    tbl[1] = '{word: 16'h8001, max_gap: 5, idle_after: 1, exp_word: 16'h8001};
    tbl[2] = '{word: 16'h5A5A, max_gap: 2, idle_after: 2, exp_word: 16'h5A5A};
    tbl[3] = '{word: 16'h0001, max_gap: 0, idle_after: 1, exp_word: 16'h0001};
    tbl[4] = '{word: 16'h8000, max_gap: 3, idle_after: 1, exp_word: 16'h8000};
    tbl[5] = '{word: 16'h7FFE, max_gap: 1, idle_after: 3, exp_word: 16'h7FFE};

    bus16.data_i = 1'b0;
    bus16.data_val_i = 1'b0;
    bus4.data_i = 1'b0;
    bus4.data_val_i = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_val", 32'(bus16.deser_data_val_o), 32'd0);
    chk("rst_data", 32'(bus16.deser_data_o), 32'd0);
    rst_n = 1'b1;
    step16(1'b0, 1'b0);

    // Directed table
    for (int v = 0; v < 6; v++) begin
      send_word(tbl[v].word, tbl[v].max_gap, tbl[v].idle_after, tbl[v].exp_word, sc_a);
    end

    // Random words, one idle cycle each
    for (int v = 0; v < 100; v++) begin
      rw = 16'($urandom);
      send_word(rw, 0, 1, rw, sc_a);
    end

    // Back-to-back words with no idle cycle
    send_word(16'hFFFF, 0, 0, 16'hFFFF, sc_a);
    send_word(16'h0000, 0, 1, 16'h0000, sc_b);
    chk("b2b_spacing", 32'(sc_b - sc_a), 32'd16);

    // Reset mid-word: make output nonzero first so the reset clear is visible
    send_word(16'hBEEF, 0, 1, 16'hBEEF, sc_a);
    for (int i = 0; i < 7; i++) begin
      step16(1'b1, 1'b1);
      chk("pre_rst_no_strobe", 32'(bus16.deser_data_val_o), 32'd0);
    end
    bus16.data_val_i = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("async_rst_data", 32'(bus16.deser_data_o), 32'd0);
    chk("async_rst_val", 32'(bus16.deser_data_val_o), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    send_word(16'h1234, 0, 1, 16'h1234, sc_a);

    // Reset coincident with the completing edge: no strobe may appear
    for (int i = 0; i < 15; i++) begin
      step16(1'b1, 1'b1);
    end
    rst_n = 1'b0;
    step16(1'b1, 1'b1);
    chk("rst_last_edge_val", 32'(bus16.deser_data_val_o), 32'd0);
    chk("rst_last_edge_data", 32'(bus16.deser_data_o), 32'd0);
    rst_n = 1'b1;
    step16(1'b0, 1'b0);
    chk("rst_last_edge_after", 32'(bus16.deser_data_val_o), 32'd0);
    send_word(16'hC0DE, 1, 1, 16'hC0DE, sc_a);

    // DATA_W = 4: bits 1,0,1,1 -> 4'b1011
    w4 = 4'b1011;
    for (int i = 3; i >= 0; i--) begin
      step4(1'b1, w4[i]);
      if (i > 0) chk("w4_no_strobe", 32'(bus4.deser_data_val_o), 32'd0);
    end
    chk("w4_strobe", 32'(bus4.deser_data_val_o), 32'd1);
    chk("w4_word", 32'(bus4.deser_data_o), 32'hB);
    step4(1'b0, 1'b0);
    chk("w4_strobe_drop", 32'(bus4.deser_data_val_o), 32'd0);
    chk("w4_hold", 32'(bus4.deser_data_o), 32'hB);
    $display("DATA_W=4 word 1011 sent -> out %b", bus4.deser_data_o);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
